// File: rtl/mseq_scheduler.sv
// Run/period sequencer for the m-sequence generator: seed load, prescaled chip steps,
// chip and period counting, finite-burst or continuous operation.
module mseq_scheduler #(
  parameter int N       = 7,
  parameter int DIV_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               CLK_50MHZ,
  input  logic               RST_N,
  input  logic               start,
  input  logic               stop,
  input  logic [DIV_W-1:0]   div,
  input  logic [N-1:0]       seed,
  input  logic [BURST_W-1:0] bursts,
  output logic               gen_load,
  output logic [N-1:0]       gen_seed,
  output logic               gen_step,
  output logic               period_tick,
  output logic [N-1:0]       chip_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  // Index of the final chip in a period: 2^N-2.
  localparam logic [N-1:0] LAST_CHIP = {{(N-1){1'b1}}, 1'b0};

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [N-1:0]       seed_q, seed_d;
  logic [BURST_W-1:0] bursts_q, bursts_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [N-1:0]       chip_q, chip_d;
  logic [BURST_W-1:0] pcnt_q, pcnt_d;

  logic step, last;

  assign step = (state_q == RUN) && (presc_q == div_q);
  assign last = (chip_q == LAST_CHIP);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    seed_d   = seed_q;
    bursts_d = bursts_q;
    presc_d  = presc_q;
    chip_d   = chip_q;
    pcnt_d   = pcnt_q;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d  = LOAD;
          div_d    = div;
          seed_d   = seed;
          bursts_d = bursts;
        end
      end
      LOAD: begin
        presc_d = '0;
        chip_d  = '0;
        pcnt_d  = '0;
        state_d = stop ? IDLE : RUN;
      end
      RUN: begin
        presc_d = step ? '0 : presc_q + 1'b1;
        if (step) begin
          chip_d = last ? '0 : chip_q + 1'b1;
          // Saturate so continuous runs never wrap back to a small count.
          if (last && (pcnt_q != '1))
            pcnt_d = pcnt_q + 1'b1;
          if (last && (bursts_q != '0) && (BURST_W'(pcnt_q + 1'b1) == bursts_q))
            state_d = DONE;
        end
        if (stop)
          state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      div_q    <= '0;
      seed_q   <= '0;
      bursts_q <= '0;
      presc_q  <= '0;
      chip_q   <= '0;
      pcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      seed_q   <= seed_d;
      bursts_q <= bursts_d;
      presc_q  <= presc_d;
      chip_q   <= chip_d;
      pcnt_q   <= pcnt_d;
    end
  end

  // All outputs are pure decodes of flops; a zero seed would lock the LFSR, so substitute 1.
  assign gen_load    = (state_q == LOAD);
  assign gen_seed    = !gen_load ? '0 : ((seed_q == '0) ? N'(1) : seed_q);
  assign gen_step    = step;
  assign period_tick = step && last;
  assign chip_idx    = chip_q;
  assign busy        = (state_q == LOAD) || (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_mseq_scheduler.sv
// Scoreboard bench for mseq_scheduler: expected output events are queued by the stimulus
// and popped by a negedge monitor whenever the DUT shows gen_load, gen_step or done.
module tb_mseq_scheduler;

  logic       clk, rst_n;
  logic       start, stop;
  logic [15:0] div;
  logic [6:0] seed;
  logic [7:0] bursts;
  logic       gen_load, gen_step, period_tick, busy, done;
  logic [6:0] gen_seed, chip_idx;

  mseq_scheduler #(.N(7), .DIV_W(16), .BURST_W(8)) dut (
    .CLK_50MHZ(clk), .RST_N(rst_n), .start(start), .stop(stop), .div(div),
    .seed(seed), .bursts(bursts), .gen_load(gen_load), .gen_seed(gen_seed),
    .gen_step(gen_step), .period_tick(period_tick), .chip_idx(chip_idx),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       load;
    logic [6:0] seed;
    logic       step;
    logic       tick;
    logic [6:0] idx;
    logic       busy;
    logic       done;
  } ev_t;

  ev_t exp_q[$];
  int  gap_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b1;
  int  cnt    = 0;

  // Monitor: gap is cycles since the previous event; expected gap 0 means unchecked.
  always @(negedge clk) begin
    ev_t act, e;
    int  g, eg;
    if (!rst_n || !mon_en) cnt = 0;
    else begin
      cnt++;
      if (gen_load || gen_step || done) begin
        act = '{gen_load, gen_seed, gen_step, period_tick, chip_idx, busy, done};
        g = cnt;
        cnt = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event act=%h gap=%0d", act, g);
        end else begin
          e  = exp_q.pop_front();
          eg = gap_q.pop_front();
          if (e.load) act.idx = e.idx;
          if (act !== e || (eg != 0 && eg != g)) begin
            errors++;
            $display("FAIL event act=%h gap=%0d exp=%h gap=%0d", act, g, e, eg);
          end
        end
      end
    end
  end

  task automatic push_run(input logic [6:0] sexp, input int dv, input int nsteps, input bit with_done);
    exp_q.push_back('{1'b1, sexp, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0});
    gap_q.push_back(0);
    for (int k = 1; k <= nsteps; k++) begin
      exp_q.push_back('{1'b0, 7'h00, 1'b1, (k % 127) == 0, 7'((k - 1) % 127), 1'b1, 1'b0});
      gap_q.push_back(dv + 1);
    end
    if (with_done) begin
      exp_q.push_back('{1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1});
      gap_q.push_back(1);
    end
  endtask

  task automatic pulse_start(input logic [15:0] d, input logic [6:0] s, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1; div = d; seed = s; bursts = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int lim);
    for (int i = 0; i < lim && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
      gap_q.delete();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] outs();
    return {7'd0, gen_load, gen_seed, gen_step, period_tick, chip_idx, busy, done};
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; div = '0; seed = '0; bursts = '0;
    #12;
    chk("reset_outputs", outs(), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_release", outs(), 32'h0);

    // 1: div=0, one period, seed 01
    push_run(7'h01, 0, 127, 1'b1);
    pulse_start(16'd0, 7'h01, 8'd1);
    drain("t1", 400);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);

    // 2: div=3, steps every 4 cycles, first in RUN cycle 4
    push_run(7'h5A, 3, 127, 1'b1);
    pulse_start(16'd3, 7'h5A, 8'd1);
    drain("t2", 800);

    // 3: zero seed substituted with 1
    push_run(7'h01, 0, 127, 1'b1);
    pulse_start(16'd0, 7'h00, 8'd1);
    drain("t3", 400);

    // 4: continuous, stop in the cycle of step 300
    push_run(7'h11, 0, 300, 1'b0);
    pulse_start(16'd0, 7'h11, 8'd0);
    n = 0;
    for (int i = 0; i < 1000 && n < 300; i++) begin
      @(negedge clk);
      if (gen_step) n++;
    end
    chk("t4_step_count", n, 300);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t4_idle_after_stop", {30'd0, busy, gen_step}, 32'd0);
    repeat (5) @(negedge clk);
    drain("t4", 10);

    // 5: asynchronous reset mid-RUN
    mon_en = 1'b0;
    pulse_start(16'd2, 7'h22, 8'd0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("t5_async_reset", outs(), 32'h0);
    #7 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_idle_after_release", outs(), 32'h0);
    end
    mon_en = 1'b1;

    // 6: start held through RUN is ignored; start+stop in IDLE does nothing
    push_run(7'h33, 1, 127, 1'b1);
    @(negedge clk);
    start = 1'b1; div = 16'd1; seed = 7'h33; bursts = 8'd1;
    repeat (100) @(negedge clk);
    seed = 7'h44; div = 16'd0;
    repeat (100) @(negedge clk);
    start = 1'b0;
    drain("t6", 200);
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_start_stop_idle", {30'd0, busy, gen_load}, 32'd0);
    end
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    drain("t6b", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
